prog_loader: RTL and testbench

Byte-stream program loader: the write-side counterpart of the instruction ROM read port.
- Accepts a framed byte stream over a valid/ready handshake, typically from a UART receiver.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory from address 0.
- Holds the core in reset while loading. Releases it only after the frame checksum matches.

---
 rtl/prog_loader_pkg.sv | 13 +
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader_assembler.sv | 33 +++
 rtl/prog_loader.sv | 118 +++++++++++
 tb/tb_prog_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_LEN   = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/prog_loader_if.sv
// Stream input and instruction-memory write bus of the program loader.
interface prog_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              load_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic              core_reset;
    logic              error;
    logic [8:0]        words_loaded;

    modport master (
        output in_data, in_valid, load_req,
        input  in_ready, mem_we, mem_addr, mem_din, core_reset, error, words_loaded
    );

    modport slave (
        input  in_data, in_valid, load_req,
        output in_ready, mem_we, mem_addr, mem_din, core_reset, error, words_loaded
    );
endinterface

// File: rtl/prog_loader_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; word_done pulses
// the cycle after the fourth byte, while word holds the completed value.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        accept,
    input  logic        clear,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic        word_done
);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt  <= '0;
            word      <= '0;
            word_done <= 1'b0;
        end else if (clear) begin
            byte_cnt  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= accept && (byte_cnt == 2'(WORD_BYTES - 1));
            if (accept) begin
                word[{byte_cnt, 3'b000} +: 8] <= in_byte;
                byte_cnt                      <= byte_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses LEN / data / CHK frames, writes words to instruction
// memory from address 0 and holds the core in reset until the checksum matches.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic           clk,
    input logic           reset,
    prog_loader_if.slave  bus
);

    state_t            state;
    state_t            state_next;
    logic [7:0]        len;
    logic [7:0]        chk_xor;
    logic [8:0]        words_loaded;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              error_q;
    logic              core_reset_q;

    logic              accept;
    logic              len_fits;
    logic              last_byte;
    logic [9:0]        len_plus1;
    logic [9:0]        depth;

    logic [1:0]        byte_cnt;
    logic [31:0]       word;
    logic              word_done;

    // load_req takes priority over a coincident byte, which is simply dropped
    assign accept    = bus.in_valid && bus.in_ready && !bus.load_req;
    assign len_plus1 = {2'b00, bus.in_data} + 10'd1;
    assign depth     = 10'd1 << ADDR_W;
    assign len_fits  = (len_plus1 <= depth);
    assign last_byte = (byte_cnt == 2'(WORD_BYTES - 1));

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .in_byte   (bus.in_data),
        .accept    (accept && (state == ST_DATA)),
        .clear     (bus.load_req),
        .byte_cnt  (byte_cnt),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_LEN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (bus.load_req) begin
            state_next = ST_LEN;
        end else begin
            case (state)
                ST_LEN:   if (accept && len_fits) state_next = ST_DATA;
                ST_DATA:  if (accept && last_byte && (words_loaded == {1'b0, len}))
                              state_next = ST_CHECK;
                ST_CHECK: if (accept)
                              state_next = (bus.in_data == chk_xor) ? ST_RUN : ST_LEN;
                ST_RUN:   state_next = ST_RUN;
                default:  state_next = ST_LEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len          <= '0;
            chk_xor      <= '0;
            words_loaded <= '0;
            mem_addr_q   <= '0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            core_reset_q <= (state_next != ST_RUN);
            if (bus.load_req) begin
                chk_xor <= '0;
                if (state != ST_RUN) words_loaded <= '0;
            end else if (accept) begin
                case (state)
                    ST_LEN: begin
                        error_q      <= !len_fits;
                        words_loaded <= '0;
                        len          <= bus.in_data;
                        chk_xor      <= len_fits ? bus.in_data : 8'h00;
                    end
                    ST_DATA: begin
                        chk_xor <= chk_xor ^ bus.in_data;
                        // Address and count step together so they line up with word_done
                        if (last_byte) begin
                            mem_addr_q   <= words_loaded[ADDR_W-1:0];
                            words_loaded <= words_loaded + 9'd1;
                        end
                    end
                    ST_CHECK: begin
                        if (bus.in_data != chk_xor) error_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready     = (state != ST_RUN);
    assign bus.mem_we       = word_done;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_din      = word;
    assign bus.core_reset   = core_reset_q;
    assign bus.error        = error_q;
    assign bus.words_loaded = words_loaded;

endmodule

// File: tb/tb_prog_loader.sv
// Directed, table-driven bench for prog_loader (ADDR_W=4, depth 16 words).
module tb_prog_loader;

    localparam int AW = 4;

    logic clk = 1'b0;
    logic reset;

    prog_loader_if #(.ADDR_W(AW)) bus ();

    prog_loader #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rst;
        bit          lreq;
        bit          vld;
        logic [7:0]  dat;
        bit          rdy;
        bit          cr;
        bit          err;
        bit          we;
        logic [3:0]  addr;
        logic [31:0] din;
        bit          chk_wl;
        logic [8:0]  wl;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    int          we_count = 0;
    logic [3:0]  last_addr;
    logic [31:0] last_din;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_count++;
            last_addr = bus.mem_addr;
            last_din  = bus.mem_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic void v(input string name, input bit rst, input bit lreq, input bit vld,
                              input logic [7:0] dat, input bit rdy, input bit cr, input bit err,
                              input bit we, input logic [3:0] addr, input logic [31:0] din,
                              input bit chk_wl, input logic [8:0] wl);
        vec_t e;
        e.name = name; e.rst = rst; e.lreq = lreq; e.vld = vld; e.dat = dat;
        e.rdy = rdy; e.cr = cr; e.err = err; e.we = we; e.addr = addr; e.din = din;
        e.chk_wl = chk_wl; e.wl = wl;
        vecs.push_back(e);
    endfunction

    // Plain accepted byte: rst=0, load_req=0, in_valid=1, words_loaded checked
    function automatic void d(input string name, input logic [7:0] dat, input bit rdy,
                              input bit cr, input bit err, input bit we, input logic [3:0] addr,
                              input logic [31:0] din, input logic [8:0] wl);
        v(name, 0, 0, 1, dat, rdy, cr, err, we, addr, din, 1, wl);
    endfunction

    task automatic applyStimulus(input vec_t e);
        @(negedge clk);
        reset        = e.rst;
        bus.load_req = e.lreq;
        bus.in_valid = e.vld;
        bus.in_data  = e.dat;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input vec_t e);
        check({e.name, " in_ready"},   bus.in_ready,   e.rdy);
        check({e.name, " core_reset"}, bus.core_reset, e.cr);
        check({e.name, " error"},      bus.error,      e.err);
        check({e.name, " mem_we"},     bus.mem_we,     e.we);
        if (e.we) begin
            check({e.name, " mem_addr"}, bus.mem_addr, e.addr);
            check({e.name, " mem_din"},  bus.mem_din,  e.din);
        end
        if (e.chk_wl) check({e.name, " words_loaded"}, bus.words_loaded, e.wl);
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        bit done = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        check("gap in_ready", done, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bit released;
        reset        = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.load_req = 1'b0;

        // Reset state
        v("reset", 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0);

        // Two-word frame, correct checksum (LEN ^ data = 0x45), with a gap
        d("t1 len", 8'h01, 1, 1, 0, 0, 0, 0, 0);
        d("t1 b0",  8'h44, 1, 1, 0, 0, 0, 0, 0);
        d("t1 b1",  8'h33, 1, 1, 0, 0, 0, 0, 0);
        d("t1 b2",  8'h22, 1, 1, 0, 0, 0, 0, 0);
        d("t1 b3",  8'h11, 1, 1, 0, 1, 4'd0, 32'h11223344, 1);
        d("t1 b4",  8'hDD, 1, 1, 0, 0, 0, 0, 1);
        v("t1 gap", 0, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 1, 1);
        d("t1 b5",  8'hCC, 1, 1, 0, 0, 0, 0, 1);
        d("t1 b6",  8'hBB, 1, 1, 0, 0, 0, 0, 1);
        d("t1 b7",  8'hAA, 1, 1, 0, 1, 4'd1, 32'hAABBCCDD, 2);
        d("t1 chk", 8'h45, 0, 0, 0, 0, 0, 0, 2);
        d("t1 run", 8'h45, 0, 0, 0, 0, 0, 0, 2);

        // Same frame with a bad checksum, then a good one-word frame clears error
        v("t2 lreq", 0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
        d("t2 len", 8'h01, 1, 1, 0, 0, 0, 0, 0);
        d("t2 b0",  8'h44, 1, 1, 0, 0, 0, 0, 0);
        d("t2 b1",  8'h33, 1, 1, 0, 0, 0, 0, 0);
        d("t2 b2",  8'h22, 1, 1, 0, 0, 0, 0, 0);
        d("t2 b3",  8'h11, 1, 1, 0, 1, 4'd0, 32'h11223344, 1);
        d("t2 b4",  8'hDD, 1, 1, 0, 0, 0, 0, 1);
        d("t2 b5",  8'hCC, 1, 1, 0, 0, 0, 0, 1);
        d("t2 b6",  8'hBB, 1, 1, 0, 0, 0, 0, 1);
        d("t2 b7",  8'hAA, 1, 1, 0, 1, 4'd1, 32'hAABBCCDD, 2);
        d("t2 badchk", 8'h00, 1, 1, 1, 0, 0, 0, 2);
        d("t2 len2", 8'h00, 1, 1, 0, 0, 0, 0, 0);
        d("t2 c0",  8'h78, 1, 1, 0, 0, 0, 0, 0);
        d("t2 c1",  8'h56, 1, 1, 0, 0, 0, 0, 0);
        d("t2 c2",  8'h34, 1, 1, 0, 0, 0, 0, 0);
        d("t2 c3",  8'h12, 1, 1, 0, 1, 4'd0, 32'h12345678, 1);
        d("t2 chk", 8'h08, 0, 0, 0, 0, 0, 0, 1);

        // Length bound for a 16-word memory
        v("t3 lreq", 0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
        d("t3 len17", 8'h10, 1, 1, 1, 0, 0, 0, 0);
        d("t3 len16", 8'h0F, 1, 1, 0, 0, 0, 0, 0);
        d("t3 b0",  8'h01, 1, 1, 0, 0, 0, 0, 0);
        d("t3 b1",  8'h02, 1, 1, 0, 0, 0, 0, 0);
        d("t3 b2",  8'h03, 1, 1, 0, 0, 0, 0, 0);
        d("t3 b3",  8'h04, 1, 1, 0, 1, 4'd0, 32'h04030201, 1);
        v("t3 abort", 0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0);

        // Abort after 6 data bytes; the coincident byte 0x99 must be dropped
        d("t4 len", 8'h01, 1, 1, 0, 0, 0, 0, 0);
        d("t4 b0",  8'h44, 1, 1, 0, 0, 0, 0, 0);
        d("t4 b1",  8'h33, 1, 1, 0, 0, 0, 0, 0);
        d("t4 b2",  8'h22, 1, 1, 0, 0, 0, 0, 0);
        d("t4 b3",  8'h11, 1, 1, 0, 1, 4'd0, 32'h11223344, 1);
        d("t4 b4",  8'hDD, 1, 1, 0, 0, 0, 0, 1);
        d("t4 b5",  8'hCC, 1, 1, 0, 0, 0, 0, 1);
        v("t4 abort", 0, 1, 1, 8'h99, 1, 1, 0, 0, 0, 0, 1, 0);
        d("t4 len2", 8'h00, 1, 1, 0, 0, 0, 0, 0);
        d("t4 c0",  8'h78, 1, 1, 0, 0, 0, 0, 0);
        d("t4 c1",  8'h56, 1, 1, 0, 0, 0, 0, 0);
        d("t4 c2",  8'h34, 1, 1, 0, 0, 0, 0, 0);
        d("t4 c3",  8'h12, 1, 1, 0, 1, 4'd0, 32'h12345678, 1);
        d("t4 chk", 8'h08, 0, 0, 0, 0, 0, 0, 1);

        // RUN ignores the stream; load_req re-enters loading
        d("t5 run0", 8'h5A, 0, 0, 0, 0, 0, 0, 1);
        d("t5 run1", 8'hA5, 0, 0, 0, 0, 0, 0, 1);
        v("t5 run2", 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1);
        d("t5 run3", 8'h3C, 0, 0, 0, 0, 0, 0, 1);
        v("t5 lreq", 0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);

        // Reset on the same cycle as the 4th byte drops the pending write
        d("t6 len", 8'h00, 1, 1, 0, 0, 0, 0, 0);
        d("t6 b0",  8'h01, 1, 1, 0, 0, 0, 0, 0);
        d("t6 b1",  8'h02, 1, 1, 0, 0, 0, 0, 0);
        d("t6 b2",  8'h03, 1, 1, 0, 0, 0, 0, 0);
        v("t6 rst", 1, 0, 1, 8'h04, 1, 1, 0, 0, 0, 0, 1, 0);
        v("t6 idle", 0, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i]);
        end

        // Gappy one-word frame: 0xDEADBEEF, CHK = 0x00^EF^BE^AD^DE = 0x22
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        we_count     = 0;
        sendByte(8'h00, 2);
        sendByte(8'hEF, 0);
        sendByte(8'hBE, 3);
        sendByte(8'hAD, 1);
        sendByte(8'hDE, 4);
        repeat (2) @(negedge clk);
        check("gap write count", we_count, 1);
        check("gap write addr", last_addr, 4'd0);
        check("gap write data", last_din, 32'hDEADBEEF);
        check("gap words_loaded", bus.words_loaded, 9'd1);
        check("gap core_reset held", bus.core_reset, 1'b1);
        sendByte(8'h22, 2);
        released = 0;
        for (int i = 0; i < 5 && !released; i++) begin
            if (bus.core_reset === 1'b0) released = 1;
            else @(negedge clk);
        end
        check("gap core released", released, 1'b1);
        check("gap error", bus.error, 1'b0);
        check("gap write count final", we_count, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
